// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave with a byte-addressable register memory.
// The block runs entirely on spi_clk. Frames open with a command byte
// (write or read), followed by a start address and any number of data bytes.
// The data pointer auto-increments and wraps at the top of memory.
`timescale 1ns/1ps
module spi_slave_mem #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter logic [7:0] CMD_READ  = 8'h03
) (
  input  logic        spi_clk,
  input  logic        rst_n,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [15:0] wr_count,
  output logic [7:0]  last_cmd
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_WR,
    ST_ADDR_RD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q;
  logic [6:0]          rx_shift_q;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          mem_q [DEPTH];
  logic [15:0]         wr_count_q, wr_count_d;
  logic [7:0]          last_cmd_q, last_cmd_d;
  logic                mem_we;

  logic                byte_done;
  logic [7:0]          rx_byte;
  logic [ADDR_W-1:0]   addr_byte;
  logic                frame_rst_n;

  // The byte being completed includes the bit sampled on this very edge.
  assign byte_done = (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, spi_mosi};
  assign addr_byte = rx_byte[ADDR_W-1:0];

  // Frame state is cleared by either the global reset or chip select going high,
  // so every frame starts cleanly at the command byte.
  assign frame_rst_n = rst_n & ~spi_cs_n;

  assign spi_miso_oe = ~spi_cs_n;
  assign spi_miso    = (state_q == ST_RDATA) && !spi_cs_n ? tx_shift_q[7] : 1'b0;
  assign wr_count    = wr_count_q;
  assign last_cmd    = last_cmd_q;

  // Next-state and datapath decisions; everything moves only on byte completion
  // except the MISO shifter, which advances on every other edge of a read.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    ptr_d      = ptr_q;
    wr_count_d = wr_count_q;
    last_cmd_d = last_cmd_q;
    mem_we     = 1'b0;
    if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          last_cmd_d = rx_byte;
          if (rx_byte == CMD_WRITE)     state_d = ST_ADDR_WR;
          else if (rx_byte == CMD_READ) state_d = ST_ADDR_RD;
          else                          state_d = ST_IGNORE;
        end
        ST_ADDR_WR: begin
          ptr_d   = addr_byte;
          state_d = ST_WDATA;
        end
        ST_ADDR_RD: begin
          // Preload the first read byte now so its MSB is on MISO before the
          // first data-byte edge: no dummy byte is needed.
          tx_shift_d = mem_q[addr_byte];
          ptr_d      = addr_byte + ADDR_W'(1);
          state_d    = ST_RDATA;
        end
        ST_WDATA: begin
          mem_we     = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          wr_count_d = wr_count_q + 16'd1;
        end
        ST_RDATA: begin
          tx_shift_d = mem_q[ptr_q];
          ptr_d      = ptr_q + ADDR_W'(1);
        end
        default: state_d = state_q;
      endcase
    end else if (state_q == ST_RDATA) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
  end

  // Per-frame registers: shift registers, bit counter and FSM state.
  always_ff @(posedge spi_clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q    <= ST_CMD;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      rx_shift_q <= rx_byte[6:0];
      tx_shift_q <= tx_shift_d;
    end
  end

  // Persistent registers: memory, pointer and counters survive between frames.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      ptr_q      <= '0;
      wr_count_q <= 16'd0;
      last_cmd_q <= 8'h00;
    end else if (!spi_cs_n) begin
      ptr_q      <= ptr_d;
      wr_count_q <= wr_count_d;
      last_cmd_q <= last_cmd_d;
      if (mem_we) mem_q[ptr_q] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench for spi_slave_mem: drives SPI mode-0 frames and checks
// read-back data, counters and MISO behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_spi_slave_mem;

  logic        spi_clk  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [15:0] wr_count;
  logic [7:0]  last_cmd;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rd_buf [4];
  logic [7:0]  dmy;
  logic        bdmy;
  logic        miso_or;
  logic        oe_and;

  spi_slave_mem #(.ADDR_W(8), .CMD_WRITE(8'h02), .CMD_READ(8'h03)) dut (
    .spi_clk     (spi_clk),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr_count    (wr_count),
    .last_cmd    (last_cmd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SPI bit: set MOSI, sample MISO mid-low-phase, then pulse the clock.
  task automatic bit_clk(input logic b, output logic m);
    spi_mosi = b;
    #5;
    m       = spi_miso;
    miso_or = miso_or | spi_miso;
    oe_and  = oe_and & spi_miso_oe;
    spi_clk = 1'b1;
    #5;
    spi_clk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    miso_or  = 1'b0;
    oe_and   = 1'b1;
    #5;
  endtask

  task automatic cs_high();
    #5;
    spi_cs_n = 1'b1;
    #10;
  endtask

  task automatic rd_frame(input logic [7:0] a, input int n);
    logic [7:0] d;
    cs_low();
    xfer(8'h03, d);
    xfer(a, d);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      rd_buf[i] = d;
    end
    cs_high();
  endtask

  initial begin
    miso_or = 1'b0;
    oe_and  = 1'b1;
    #20;
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_last_cmd", 32'(last_cmd), 32'h00);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    rst_n = 1'b1;
    #10;

    // Basic write of four bytes at 0x10
    cs_low();
    xfer(8'h02, dmy); xfer(8'h10, dmy);
    xfer(8'hDE, dmy); xfer(8'hAD, dmy); xfer(8'hBE, dmy); xfer(8'hEF, dmy);
    cs_high();
    chk("wr_count_after_write", 32'(wr_count), 32'd4);
    chk("last_cmd_write", 32'(last_cmd), 32'h02);

    // Read back three bytes with no dummy byte
    rd_frame(8'h10, 3);
    chk("read_b0", 32'(rd_buf[0]), 32'hDE);
    chk("read_b1", 32'(rd_buf[1]), 32'hAD);
    chk("read_b2", 32'(rd_buf[2]), 32'hBE);
    chk("read_oe_during_frame", 32'(oe_and), 32'd1);
    chk("wr_count_after_read", 32'(wr_count), 32'd4);
    chk("last_cmd_read", 32'(last_cmd), 32'h03);
    chk("oe_idle", 32'(spi_miso_oe), 32'd0);
    rd_frame(8'h13, 1);
    chk("read_13", 32'(rd_buf[0]), 32'hEF);

    // Address wrap at the top of memory
    cs_low();
    xfer(8'h02, dmy); xfer(8'hFE, dmy);
    xfer(8'h11, dmy); xfer(8'h22, dmy); xfer(8'h33, dmy);
    cs_high();
    chk("wr_count_after_wrap", 32'(wr_count), 32'd7);
    rd_frame(8'hFF, 2);
    chk("wrap_read_ff", 32'(rd_buf[0]), 32'h22);
    chk("wrap_read_00", 32'(rd_buf[1]), 32'h33);
    rd_frame(8'hFE, 3);
    chk("wrap_read3_fe", 32'(rd_buf[0]), 32'h11);
    chk("wrap_read3_ff", 32'(rd_buf[1]), 32'h22);
    chk("wrap_read3_00", 32'(rd_buf[2]), 32'h33);

    // Abort mid-byte: partial byte is discarded
    cs_low();
    xfer(8'h02, dmy); xfer(8'h20, dmy); xfer(8'hA5, dmy);
    for (int i = 0; i < 5; i++) bit_clk(1'b1, bdmy);
    cs_high();
    chk("wr_count_after_abort", 32'(wr_count), 32'd8);
    rd_frame(8'h20, 2);
    chk("abort_read_20", 32'(rd_buf[0]), 32'hA5);
    chk("abort_read_21", 32'(rd_buf[1]), 32'h00);

    // Unknown command: ignored frame, MISO stays low
    cs_low();
    xfer(8'h5A, dmy); xfer(8'h20, dmy); xfer(8'hFF, dmy); xfer(8'hFF, dmy);
    chk("unk_oe_now", 32'(spi_miso_oe), 32'd1);
    chk("unk_oe_whole_frame", 32'(oe_and), 32'd1);
    chk("unk_miso_quiet", 32'(miso_or), 32'd0);
    cs_high();
    chk("unk_last_cmd", 32'(last_cmd), 32'h5A);
    chk("unk_wr_count", 32'(wr_count), 32'd8);
    rd_frame(8'h20, 2);
    chk("unk_read_20", 32'(rd_buf[0]), 32'hA5);
    chk("unk_read_21", 32'(rd_buf[1]), 32'h00);

    // Reset pulse during a write data byte, then continue in the same cs frame
    cs_low();
    xfer(8'h02, dmy); xfer(8'h00, dmy);
    for (int i = 0; i < 4; i++) bit_clk(1'b1, bdmy);
    rst_n = 1'b0;
    #5;
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_last_cmd", 32'(last_cmd), 32'h00);
    rst_n = 1'b1;
    #5;
    xfer(8'h02, dmy); xfer(8'h00, dmy); xfer(8'h77, dmy);
    cs_high();
    chk("postrst_wr_count", 32'(wr_count), 32'd1);
    chk("postrst_last_cmd", 32'(last_cmd), 32'h02);
    rd_frame(8'hFE, 3);
    chk("postrst_read_fe", 32'(rd_buf[0]), 32'h00);
    chk("postrst_read_ff", 32'(rd_buf[1]), 32'h00);
    chk("postrst_read_00", 32'(rd_buf[2]), 32'h77);
    rd_frame(8'h10, 2);
    chk("postrst_read_10", 32'(rd_buf[0]), 32'h00);
    chk("postrst_read_11", 32'(rd_buf[1]), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
